serial_adder_fsm: RTL and testbench
===================================

Name: serial_adder_fsm

Overview:
- Parametrised bit-serial adder that adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
- The datapath is a single full-adder cell built from two half-adder stages, plus a carry flip-flop.
- A start/busy/done handshake with a small FSM replaces the purely combinational half adder.
- Used where area matters more than latency; it is the sequential successor to the gate-level adder cells.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..64).
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived localparam, not overridable.

Ports:
- clk_in  input  1  rising-edge clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- carry_in  input  1  carry-in; captured on the accepting edge.
- busy_out  output  1  high while in ADD.
- done_out  output  1  one-cycle pulse when the result is valid.
- sum_out  output  WIDTH  registered sum; held until the next result.
- carry_out  output  1  registered carry-out; held with sum_out.

Behaviour:
- Reset (async, rst_n_in=0):
  - state=IDLE.
  - busy_out=0, done_out=0, sum_out=0, carry_out=0.
  - Shift registers, carry FF and counter are cleared.
  - Reset asserted mid-operation aborts the operation; no done_out pulse is produced.
- States: IDLE, ADD, DONE (2-bit encoding).
- IDLE:
  - If start_in=1 at edge E0: load a_sh<=a_in, b_sh<=b_in, c<=carry_in, cnt<=0, state<=ADD.
  - Otherwise stay in IDLE.
- ADD, once per edge:
  - s = a_sh[0]^b_sh[0]^c; c <= majority(a_sh[0],b_sh[0],c).
  - a_sh, b_sh shift right; s is shifted into the MSB of the result register r.
  - cnt increments.
  - On the edge where cnt==WIDTH-1 (edge E_WIDTH): sum_out<=final r, carry_out<=final carry, done_out<=1, state<=DONE.
- DONE:
  - Lasts exactly one cycle; done_out=1 for that cycle.
  - Next edge: done_out<=0, state<=IDLE.
- Latency: start accepted at E0; result and done_out are visible after E_WIDTH.
- Throughput: one operation per WIDTH+2 cycles.
- start_in while in ADD or DONE: ignored; not queued.
- Operand inputs change during ADD: no effect, since the values were captured at E0.
- busy_out = (state==ADD), registered/decoded without glitches. busy_out is low in DONE.
- sum_out/carry_out change only on the E_WIDTH edge (or on reset); they are stable otherwise.
- WIDTH=1: exactly one ADD cycle; done_out appears after E1.
- Arithmetic: {carry_out,sum_out} == a_in + b_in + carry_in, modulo 2^(WIDTH+1).

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port overflow_out (1 bit), the two's-complement signed overflow = (carry into MSB) XOR (carry out of MSB).
  - Registered together with sum_out; reset value 0.
  - Valid alongside done_out and held until the next result.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package serial_adder_pkg holds:
  - State encoding ST_IDLE=2'b00, ST_ADD=2'b01, ST_DONE=2'b10 (typedef state_t).
  - Default WIDTH constant.
- Sub-module full_adder_cell: ports a_in, b_in, c_in, sum_out, carry_out. Purely combinational, composed of two half-adder stages plus an OR gate.
- The FSM, counter and shift registers stay in serial_adder_fsm.

Test Plan (WIDTH=8 unless noted):
- Basic add: a=8'h0F, b=8'h01, cin=0, start pulse → busy_out high for 8 cycles, done_out pulse after E8, sum_out=8'h10, carry_out=0.
- Wrap-around: a=8'hFF, b=8'h01, cin=0 → sum_out=8'h00, carry_out=1. Then a=8'hFF, b=8'hFF, cin=1 → sum_out=8'hFF, carry_out=1.
- Start while busy: second start_in with a=8'h55 during ADD → ignored; first result is unchanged; exactly one done_out pulse.
- Reset mid-operation: rst_n_in=0 at ADD cycle 4 → all outputs 0 immediately, no done_out. After release, a=8'h20, b=8'h22 → sum_out=8'h42.
- Boundary WIDTH=1: a=1, b=1, cin=1 → done after E1, sum_out=1, carry_out=1.
- With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 → sum_out=8'h80, overflow_out=1. a=8'hFF, b=8'h01 → overflow_out=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default width for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational full adder: two half-adder stages whose carries are ORed.
module full_adder_cell (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic carry_out
);

  logic ha1_sum, ha1_carry, ha2_carry;

  assign ha1_sum   = a_in ^ b_in;
  assign ha1_carry = a_in & b_in;
  assign sum_out   = ha1_sum ^ c_in;
  assign ha2_carry = ha1_sum & c_in;
  assign carry_out = ha1_carry | ha2_carry;

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder, LSB first, with start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output.
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow_out
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_msb;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  full_adder_cell u_fa (
    .a_in      (a_sh_q[0]),
    .b_in      (b_sh_q[0]),
    .c_in      (c_q),
    .sum_out   (fa_sum),
    .carry_out (fa_cout)
  );

  assign last_bit = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_d     = r_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    // New sum bit enters at the MSB so the LSB-first stream ends up in order
    s_msb            = '0;
    s_msb[WIDTH-1]   = fa_sum;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          c_d     = carry_in;
          r_d     = '0;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = fa_cout;
        r_d    = (r_q >> 1) | s_msb;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = r_d;
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_out  = (state_q == ST_ADD);
  assign done_out  = (state_q == ST_DONE);
  assign sum_out   = sum_q;
  assign carry_out = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  // On the MSB step c_q is the carry into the MSB and fa_cout the carry out
  logic ovf_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_q <= 1'b0;
    end else if ((state_q == ST_ADD) && last_bit) begin
      ovf_q <= c_q ^ fa_cout;
    end
  end

  assign overflow_out = ovf_q;
`else
  // Without the overflow output the MSB carries are not observed separately
`endif

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Randomised self-checking bench for serial_adder_fsm (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder_fsm #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start8), .a_in(a8), .b_in(b8),
    .carry_in(cin8), .busy_out(busy8), .done_out(done8), .sum_out(sum8),
    .carry_out(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .overflow_out(ovf8)
`endif
  );

  serial_adder_fsm #(.WIDTH(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .a_in(a1), .b_in(b1),
    .carry_in(cin1), .busy_out(busy1), .done_out(done1), .sum_out(sum1),
    .carry_out(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .overflow_out(ovf1)
`endif
  );

  // Reference: full-precision sum of the operands, truncated to WIDTH+1 bits
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int s;
    s = int'(a) + int'(b) + int'(cin);
    return s[8:0];
  endfunction

  function automatic logic [1:0] model1(input logic a, input logic b, input logic cin);
    int s;
    s = int'(a) + int'(b) + int'(cin);
    return s[1:0];
  endfunction

  function automatic logic ovf_model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return (s > 127) || (s < -128);
  endfunction

  // Runs one operation on the chosen instance; returns result, latency in edges after
  // the accepting edge, busy cycle count, output-change count during ADD, and the
  // done/busy state one cycle after the done pulse.
  task automatic do_op(input bit w1, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [8:0] res, output int lat, output int busy_n,
                       output int unstable, output logic post_flags);
    logic [8:0]  prev, cur;
    logic [31:0] rnd;
    prev = w1 ? {7'b0, cout1, sum1} : {cout8, sum8};
    @(negedge clk);
    if (w1) begin start1 = 1'b1; a1 = a[0:0]; b1 = b[0:0]; cin1 = cin; end
    else    begin start8 = 1'b1; a8 = a;      b8 = b;      cin8 = cin; end
    @(negedge clk);
    start1 = 1'b0;
    start8 = 1'b0;
    rnd = $urandom;
    a8 = rnd[7:0]; b8 = rnd[15:8]; cin8 = rnd[16]; a1 = rnd[17:17]; b1 = rnd[18:18]; cin1 = rnd[19];
    lat = -1;
    busy_n = 0;
    unstable = 0;
    for (int n = 0; n < 40; n++) begin
      if (w1 ? done1 : done8) begin
        lat = n;
        break;
      end
      if (w1 ? busy1 : busy8) busy_n++;
      cur = w1 ? {7'b0, cout1, sum1} : {cout8, sum8};
      if (cur != prev) unstable++;
      @(negedge clk);
    end
    res = w1 ? {7'b0, cout1, sum1} : {cout8, sum8};
    @(negedge clk);
    post_flags = w1 ? (done1 | busy1) : (done8 | busy8);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_w8 got %h want 000", {busy8, done8, cout8, sum8});
    end
    vectors++;
    if ({busy1, done1, cout1, sum1} !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_w1 got %h want 0", {busy1, done1, cout1, sum1});
    end
`ifdef SERIAL_ADDER_OVF_EN
    vectors++;
    if ({ovf8, ovf1} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ovf got %b want 00", {ovf8, ovf1});
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] ta [3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'hFF};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] res;
    int lat, busy_n, unstable;
    logic post;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, ta[i], tb[i], tc[i], res, lat, busy_n, unstable, post);
      vectors++;
      if (res !== model8(ta[i], tb[i], tc[i])) begin
        miscompares++;
        $display("FAIL directed_sum[%0d] got %h want %h", i, res, model8(ta[i], tb[i], tc[i]));
      end
      vectors++;
      if (lat != 8 || busy_n != 8) begin
        miscompares++;
        $display("FAIL directed_timing[%0d] got lat=%0d busy=%0d want lat=8 busy=8", i, lat, busy_n);
      end
      vectors++;
      if (unstable != 0 || post !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_hold[%0d] got changes=%0d post=%b want 0 0", i, unstable, post);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rnd;
    logic [8:0]  res;
    int lat, busy_n, unstable;
    logic post;
    for (int i = 0; i < 24; i++) begin
      rnd = $urandom;
      do_op(1'b0, rnd[7:0], rnd[15:8], rnd[16], res, lat, busy_n, unstable, post);
      vectors++;
      if (res !== model8(rnd[7:0], rnd[15:8], rnd[16]) || lat != 8 || unstable != 0) begin
        miscompares++;
        $display("FAIL random[%0d] got %h lat=%0d chg=%0d want %h lat=8 chg=0", i, res, lat,
                 unstable, model8(rnd[7:0], rnd[15:8], rnd[16]));
      end
`ifdef SERIAL_ADDER_OVF_EN
      vectors++;
      if (ovf8 !== ovf_model8(rnd[7:0], rnd[15:8], rnd[16])) begin
        miscompares++;
        $display("FAIL random_ovf[%0d] got %b want %b", i, ovf8, ovf_model8(rnd[7:0], rnd[15:8], rnd[16]));
      end
`endif
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0, late_busy = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      if (done8) dones++;
      if (n >= 10 && busy8) late_busy++;
      start8 = (n <= 8);
      a8 = 8'h55;
      b8 = 8'h55;
      @(negedge clk);
    end
    start8 = 1'b0;
    vectors++;
    if (dones != 1 || late_busy != 0) begin
      miscompares++;
      $display("FAIL busy_start_pulses got done=%0d late_busy=%0d want 1 0", dones, late_busy);
    end
    vectors++;
    if ({cout8, sum8} !== 9'h010) begin
      miscompares++;
      $display("FAIL busy_start_sum got %h want 010", {cout8, sum8});
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    logic [8:0] res;
    int lat, busy_n, unstable;
    logic post;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got %h want 000", {busy8, done8, cout8, sum8});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL reset_mid_abort got activity=%0d want 0", dones);
    end
    do_op(1'b0, 8'h20, 8'h22, 1'b0, res, lat, busy_n, unstable, post);
    vectors++;
    if (res !== 9'h042 || lat != 8) begin
      miscompares++;
      $display("FAIL reset_mid_after got %h lat=%0d want 042 lat=8", res, lat);
    end
  endtask

  task automatic test_width1();
    logic [8:0] res;
    logic [2:0] v;
    int lat, busy_n, unstable;
    logic post;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      do_op(1'b1, {7'b0, v[2]}, {7'b0, v[1]}, v[0], res, lat, busy_n, unstable, post);
      vectors++;
      if (res[1:0] !== model1(v[2], v[1], v[0]) || lat != 1 || busy_n != 1 || post !== 1'b0) begin
        miscompares++;
        $display("FAIL width1[%0d] got %b lat=%0d busy=%0d post=%b want %b lat=1 busy=1 post=0",
                 i, res[1:0], lat, busy_n, post, model1(v[2], v[1], v[0]));
      end
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [8:0] res;
    int lat, busy_n, unstable;
    logic post;
    do_op(1'b0, 8'h7F, 8'h01, 1'b0, res, lat, busy_n, unstable, post);
    vectors++;
    if (res[7:0] !== 8'h80 || ovf8 !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_7f got sum=%h ovf=%b want 80 1", res[7:0], ovf8);
    end
    do_op(1'b0, 8'hFF, 8'h01, 1'b0, res, lat, busy_n, unstable, post);
    vectors++;
    if (res[7:0] !== 8'h00 || ovf8 !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_ff got sum=%h ovf=%b want 00 0", res[7:0], ovf8);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_width1();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
